// File: rtl/ram_arb_pkg.sv
// Shared types and sizing helpers for the RAM arbiter and its round-robin picker.
package ram_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int ADR_W    = 10;
    localparam int DATA_W   = 8;

    // Requester index width; a single requester still needs one bit of tag.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int ID_W = id_width(NREQ_DEF);

    typedef struct packed {
        logic              write;
        logic [ADR_W-1:0]  addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_picker
    import ram_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        int pos;
        pos   = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NREQ requesters.
// Two-stage pipeline: issue registers drive the RAM, a tag stage routes read data back.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int ADR  = ADR_W,
    parameter int DATA = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*ADR-1:0]  req_addr,
    input  logic [NREQ*DATA-1:0] req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DATA-1:0]      rsp_data,
    output logic                 ram_cs,
    output logic                 ram_write,
    output logic                 ram_read,
    output logic [ADR-1:0]       ram_addr,
    output logic [DATA-1:0]      ram_din,
    input  logic [DATA-1:0]      ram_dout
);

    localparam int IW = id_width(NREQ);

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_next;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            gfound;

    cmd_t            sel_cmd;
    cmd_t            issue_q;
    logic [IW-1:0]   s1_id;
    logic            s1_rd;
    logic            s2_valid;
    logic [IW-1:0]   s2_id;

    rr_picker #(
        .N  (NREQ),
        .IW (IW)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .found (gfound)
    );

    // Ready is held low while in reset so nothing is handed off to a pipeline being cleared.
    assign req_ready = {NREQ{rst_n}} & grant;

    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_cmd.write = req_write[i];
                sel_cmd.addr  = req_addr[i*ADR +: ADR];
                sel_cmd.wdata = req_wdata[i*DATA +: DATA];
            end
        end
    end

    always_comb begin
        ptr_next = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gfound) begin
            ptr <= ptr_next;
        end
    end

    // Address and data hold when idle; only chip select falls, which keeps the RAM quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cs  <= 1'b0;
            issue_q <= '0;
            s1_id   <= '0;
        end else begin
            ram_cs <= gfound;
            if (gfound) begin
                issue_q <= sel_cmd;
                s1_id   <= gidx;
            end
        end
    end

    // Strobes are qualified by chip select, so write and read can never overlap.
    assign ram_write = ram_cs & issue_q.write;
    assign ram_read  = ram_cs & ~issue_q.write;
    assign ram_addr  = issue_q.addr;
    assign ram_din   = issue_q.wdata;
    assign s1_rd     = ~issue_q.write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_id    <= '0;
        end else begin
            s2_valid <= s1_rd & ram_cs;
            s2_id    <= s1_id;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = s2_valid && (s2_id == IW'(i));
        end
    end

    assign rsp_data = ram_dout;

    a_no_rw_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(ram_write && ram_read));
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_valid));
    a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (req_ready & ~req_valid) == '0);
    a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n)
        int'(ptr) < NREQ);

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter sharing one single-port synchronous RAM (active-high CS/WRITE/READ, registered read data) among NREQ requesters. Each requester issues read or write commands over a valid/ready handshake. The arbiter grants at most one command per cycle, drives the RAM control/address/data lines from registers, and routes read data back to the owning requester with a one-cycle valid pulse. It sits between the client blocks and the RAM instance.

## Interface
- NREQ, 4: number of requesters (2..8)
- ADR, 10: RAM address width
- DATA, 8: RAM data width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  bit i: requester i has a command
- req_write  in  NREQ  bit i: 1 = write, 0 = read
- req_addr  in  NREQ*ADR  requester i address at [i*ADR +: ADR]
- req_wdata  in  NREQ*DATA  requester i write data at [i*DATA +: DATA]
- req_ready  out  NREQ  one-hot or zero; bit i: command i accepted this cycle
- rsp_valid  out  NREQ  one-hot or zero; bit i: rsp_data holds requester i read result
- rsp_data  out  DATA  read data, shared by all requesters
- ram_cs  out  1  RAM chip select
- ram_write  out  1  RAM write strobe
- ram_read  out  1  RAM read strobe
- ram_addr  out  ADR  RAM address
- ram_din  out  DATA  RAM write data
- ram_dout  in  DATA  RAM registered read data

## Operation
- Arbitration: search req_valid from pointer ptr upward, modulo NREQ. The first set bit i wins, and req_ready[i]=1 combinationally in that cycle. No valid bits means no grant.
- ptr resets to 0. After each grant to i, ptr <= (i+1) mod NREQ. ptr is unchanged on idle cycles.
- Requester rule: hold valid/write/addr/wdata stable until ready. The arbiter never drops a held request, so starvation is bounded by NREQ-1 grants.
- Issue stage (registers): on grant, ram_cs<=1, ram_write<=req_write[i], ram_read<=~req_write[i], ram_addr/ram_din <= requester i fields, s1_id<=i, s1_rd<=~req_write[i]. With no grant, ram_cs/ram_write/ram_read<=0 and ram_addr/ram_din hold their values.
- Response stage: s2_valid<=s1_rd & issue-valid, s2_id<=s1_id. rsp_valid[s2_id]=s2_valid, and rsp_data=ram_dout (pass-through).
- Writes produce no response.
- Never assert ram_write and ram_read together.
- Issue and response stages run fully pipelined: one new command per cycle, back-to-back to any mix of requesters.

## Timing
- Reset (async assert, sync-safe deassert): ptr=0, req_ready=0, ram_cs=ram_write=ram_read=0, ram_addr=0, ram_din=0, s1/s2 cleared, rsp_valid=0. rsp_data follows ram_dout.
- Accept cycle T: req_valid[i]&req_ready[i] at posedge ending T.
- T+1: RAM lines carry the command, and the RAM acts on the posedge ending T+1.
- T+2: for reads, rsp_valid[i]=1 for one cycle with rsp_data = RAM[addr]. Read latency is 2 cycles from accept.
- Write at T then read of the same address at T+1: the read returns the new data. The RAM orders them sequentially, and no forwarding is needed.
- Simultaneous requests: only one bit of req_ready is set. All others wait with no penalty beyond arbitration order.
- rst_n asserted mid-operation: in-flight commands are discarded, no rsp_valid is emitted, and a partially issued write may or may not land in the RAM.
- After rst_n deasserts, first grant is possible in the first clock.

## Structure
- Package ram_arb_pkg: ID width localparam ($clog2(NREQ), min 1) and a command struct {write, addr, wdata} shared by the issue register and the mux.
- Sub-module rr_picker: combinational (req vector, ptr) -> one-hot grant plus encoded index. It is reusable by other shared-resource blocks.
- Top holds ptr, the issue registers, the response tag pipeline, and the per-requester field mux.

## Test plan
- Single read: preload RAM[0x005]=0xA5, requester 2 reads 0x005 at T, so req_ready[2]=1 at T, ram_read=1 at T+1, rsp_valid=4'b0100 with rsp_data=0xA5 at T+2.
- Write then read back: requester 0 writes 0x3C to 0x3FF (wrap-top address) at T and reads 0x3FF at T+1, giving rsp_valid[0] with 0x3C at T+3. There is no response for the write.
- Round-robin fairness: all four requesters hold reads continuously from reset. Grants go 0,1,2,3,0,1… with one per cycle and responses tagged in the same order 2 cycles later.
- Pointer skip: ptr=3 with only requesters 1 and 2 valid grants 1 and then 2. With no valid bits, ram_cs=0 and ptr is unchanged.
- Reset mid-flight: reads accepted at T and T+1, rst_n low during T+1. All outputs go to their reset values immediately, no rsp_valid ever fires for those reads, and a new read after release returns correct data.
